// File: rtl/hazard_pkg.sv
// Shared definitions for the forwarding/hazard unit: slot layout inside the
// in-flight tracker, the bubble value, select encodings and the register compare.
package hazard_pkg;

    // Flag bits sit at the bottom of a slot; rd and the rs array follow.
    localparam int OFF_VALID    = 0;
    localparam int OFF_REGWRITE = 1;
    localparam int OFF_MEMREAD  = 2;
    localparam int OFF_MEMWRITE = 3;
    localparam int OFF_RD       = 4;

    localparam int MAX_AW     = 32;
    localparam int MAX_SLOT_W = 1024;

    // A bubble is an all-zero slot, so valid, regwrite and every address read 0.
    localparam logic [MAX_SLOT_W-1:0] BUBBLE = '0;

    localparam int SEL_RF        = 0;
    localparam int STORE_DATA_OP = 1;

    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int rs_offset(input int reg_aw);
        return OFF_RD + reg_aw;
    endfunction

    function automatic int slot_width(input int num_src, input int reg_aw);
        return OFF_RD + reg_aw * (num_src + 1);
    endfunction

    // x0 is hard-wired to zero, so a write to it never produces a usable result.
    function automatic logic writes_reg(input logic valid, input logic regwrite,
                                        input logic [MAX_AW-1:0] rd,
                                        input logic [MAX_AW-1:0] r);
        return valid && regwrite && (rd == r) && (r != '0);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority bypass select for one source register against the post-EX stages;
// the youngest stage holding a usable result wins.
module fwd_match
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1,
    localparam int SEL_W   = sel_width(DEPTH)
) (
    input  logic [REG_AW-1:0]       addr,
    input  logic [DEPTH-1:0]        valid,
    input  logic [DEPTH-1:0]        regwrite,
    input  logic [DEPTH-1:0]        memread,
    input  logic [DEPTH*REG_AW-1:0] rd,
    output logic [SEL_W-1:0]        sel
);

    // Scan oldest to youngest so the last hit written is the youngest stage.
    always_comb begin
        sel = SEL_W'(SEL_RF);
        for (int k = DEPTH; k >= 1; k--) begin
            if (writes_reg(valid[k-1], regwrite[k-1],
                           MAX_AW'(rd[(k-1)*REG_AW +: REG_AW]), MAX_AW'(addr))
                && !(memread[k-1] && (k <= LOAD_LAT)))
                sel = SEL_W'(k);
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Tracks in-flight destinations from ID/EX through DEPTH later stages and
// produces EX operand bypass selects, load-use stalls and load-to-store forwarding.
module fwd_hazard_unit
    import hazard_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16,
    localparam int SEL_W   = sel_width(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_regwrite,
    input  logic                      id_memread,
    input  logic                      id_memwrite,
    input  logic                      flush,
    output logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel,
    output logic                      mem_src,
    output logic                      stall,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam int SLOT_W = slot_width(NUM_SRC, REG_AW);
    localparam int RS_OFF = rs_offset(REG_AW);
    localparam logic [SLOT_W-1:0] SLOT_BUBBLE = BUBBLE[SLOT_W-1:0];

    // slot[0] is the EX slot, slot[k] is k stages past EX.
    logic [DEPTH:0][SLOT_W-1:0] slot;
    logic [SLOT_W-1:0]          id_slot;

    logic [DEPTH-1:0]           st_valid;
    logic [DEPTH-1:0]           st_regwrite;
    logic [DEPTH-1:0]           st_memread;
    logic [DEPTH*REG_AW-1:0]    st_rd;
    logic [NUM_SRC*SEL_W-1:0]   raw_sel;

    always_comb begin
        id_slot                             = SLOT_BUBBLE;
        id_slot[OFF_VALID]                  = id_valid;
        id_slot[OFF_REGWRITE]               = id_regwrite;
        id_slot[OFF_MEMREAD]                = id_memread;
        id_slot[OFF_MEMWRITE]               = id_memwrite;
        id_slot[OFF_RD +: REG_AW]           = id_rd;
        id_slot[RS_OFF +: NUM_SRC*REG_AW]   = id_rs;
    end

    // The tracker advances every cycle; a stalled or flushed ID slot becomes a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k <= DEPTH; k++)
                slot[k] <= SLOT_BUBBLE;
            stall_cnt <= '0;
        end else begin
            for (int k = 1; k <= DEPTH; k++)
                slot[k] <= slot[k-1];
            slot[0] <= (id_valid && !stall && !flush) ? id_slot : SLOT_BUBBLE;
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        st_valid    = '0;
        st_regwrite = '0;
        st_memread  = '0;
        st_rd       = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            st_valid[k-1]                   = slot[k][OFF_VALID];
            st_regwrite[k-1]                = slot[k][OFF_REGWRITE];
            st_memread[k-1]                 = slot[k][OFF_MEMREAD];
            st_rd[(k-1)*REG_AW +: REG_AW]   = slot[k][OFF_RD +: REG_AW];
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_match #(
            .REG_AW   (REG_AW),
            .DEPTH    (DEPTH),
            .LOAD_LAT (LOAD_LAT)
        ) u_match (
            .addr     (slot[0][RS_OFF + i*REG_AW +: REG_AW]),
            .valid    (st_valid),
            .regwrite (st_regwrite),
            .memread  (st_memread),
            .rd       (st_rd),
            .sel      (raw_sel[i*SEL_W +: SEL_W])
        );
    end

    assign ex_fwd_sel = slot[0][OFF_VALID] ? raw_sel : '0;

    // A load still within its latency blocks any consumer, except store data
    // against an EX-slot load, which is picked up later through mem_src.
    always_comb begin
        stall = 1'b0;
        if (id_valid && !flush) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                for (int p = 0; p < LOAD_LAT; p++) begin
                    if (slot[p][OFF_MEMREAD]
                        && writes_reg(slot[p][OFF_VALID], slot[p][OFF_REGWRITE],
                                      MAX_AW'(slot[p][OFF_RD +: REG_AW]),
                                      MAX_AW'(id_rs[i*REG_AW +: REG_AW]))
                        && !(id_memwrite && (i == STORE_DATA_OP) && (p == 0)))
                        stall = 1'b1;
                end
            end
        end
    end

    assign mem_src = slot[1][OFF_VALID] && slot[1][OFF_MEMWRITE]
                  && slot[2][OFF_VALID] && slot[2][OFF_MEMREAD]
                  && (slot[2][OFF_RD +: REG_AW] != '0)
                  && (slot[2][OFF_RD +: REG_AW]
                      == slot[1][RS_OFF + STORE_DATA_OP*REG_AW +: REG_AW]);

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: a default instance and a DEPTH=3/LOAD_LAT=2 instance
// share one ID stream, checked against directed vectors and an age-based model.
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [4:0]  id_rd;
    logic        id_regwrite;
    logic        id_memread;
    logic        id_memwrite;
    logic        flush;

    logic [3:0]  ex_fwd_sel_a, ex_fwd_sel_b;
    logic        mem_src_a, mem_src_b;
    logic        stall_a, stall_b;
    logic [15:0] stall_cnt_a, stall_cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit u_dut_a (
        .clk (clk), .reset (reset), .id_valid (id_valid), .id_rs (id_rs),
        .id_rd (id_rd), .id_regwrite (id_regwrite), .id_memread (id_memread),
        .id_memwrite (id_memwrite), .flush (flush), .ex_fwd_sel (ex_fwd_sel_a),
        .mem_src (mem_src_a), .stall (stall_a), .stall_cnt (stall_cnt_a)
    );

    fwd_hazard_unit #(.DEPTH(3), .LOAD_LAT(2)) u_dut_b (
        .clk (clk), .reset (reset), .id_valid (id_valid), .id_rs (id_rs),
        .id_rd (id_rd), .id_regwrite (id_regwrite), .id_memread (id_memread),
        .id_memwrite (id_memwrite), .flush (flush), .ex_fwd_sel (ex_fwd_sel_b),
        .mem_src (mem_src_b), .stall (stall_b), .stall_cnt (stall_cnt_b)
    );

    typedef struct {
        bit       rst, v, rw, mr, mw, fl, chk;
        bit [4:0] rs0, rs1, rd;
        int       e_s0, e_s1, e_ms, e_st, e_cnt;
    } vec_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite, memread, memwrite;
        logic [4:0] rs0, rs1;
    } inst_t;

    // Model: hist[c][a] is the instruction that entered EX a cycles ago (a=0 is EX).
    localparam int CFG_D [2] = '{2, 3};
    localparam int CFG_L [2] = '{1, 2};
    inst_t hist [2][4];
    int    mcnt [2];
    inst_t cur_id;
    bit    cur_fl;
    vec_t  tbl [$];

    function automatic vec_t mk(int rst, int v, int rs0, int rs1, int rd, int rw, int mr,
                                int mw, int fl, int s0, int s1, int ms, int st, int cnt);
        vec_t r;
        r.rst = (rst != 0); r.v = (v != 0); r.rw = (rw != 0); r.mr = (mr != 0);
        r.mw = (mw != 0); r.fl = (fl != 0); r.chk = 1'b1;
        r.rs0 = 5'(rs0); r.rs1 = 5'(rs1); r.rd = 5'(rd);
        r.e_s0 = s0; r.e_s1 = s1; r.e_ms = ms; r.e_st = st; r.e_cnt = cnt;
        return r;
    endfunction

    function automatic vec_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic bit usable(int c, int age, logic [4:0] r);
        inst_t s;
        s = hist[c][age];
        return s.valid && s.regwrite && s.rd == r && r != 0 && !(s.memread && age <= CFG_L[c]);
    endfunction

    function automatic int modelSel(int c, logic [4:0] r);
        if (!hist[c][0].valid) return 0;
        for (int age = 1; age <= CFG_D[c]; age++)
            if (usable(c, age, r)) return age;
        return 0;
    endfunction

    function automatic bit modelStall(int c);
        inst_t s;
        if (!cur_id.valid || cur_fl) return 0;
        for (int age = 0; age < CFG_L[c]; age++) begin
            s = hist[c][age];
            if (s.valid && s.memread && s.regwrite && s.rd != 0) begin
                if (cur_id.rs0 == s.rd) return 1;
                if (cur_id.rs1 == s.rd && !(cur_id.memwrite && age == 0)) return 1;
            end
        end
        return 0;
    endfunction

    function automatic bit modelMemSrc(int c);
        inst_t st, ld;
        st = hist[c][1];
        ld = hist[c][2];
        return st.valid && st.memwrite && ld.valid && ld.memread && ld.rd != 0 && ld.rd == st.rs1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset       = v.rst;
        id_valid    = v.v;
        id_rs       = {v.rs1, v.rs0};
        id_rd       = v.rd;
        id_regwrite = v.rw;
        id_memread  = v.mr;
        id_memwrite = v.mw;
        flush       = v.fl;
        cur_id      = '{valid: v.v, rd: v.rd, regwrite: v.rw, memread: v.mr,
                        memwrite: v.mw, rs0: v.rs0, rs1: v.rs1};
        cur_fl      = v.fl;
    endtask

    task automatic checkOutput(input vec_t v);
        chk("tbl_sel0",  32'(ex_fwd_sel_a[1:0]), 32'(v.e_s0));
        chk("tbl_sel1",  32'(ex_fwd_sel_a[3:2]), 32'(v.e_s1));
        chk("tbl_memsrc", 32'(mem_src_a), 32'(v.e_ms));
        chk("tbl_stall", 32'(stall_a), 32'(v.e_st));
        chk("tbl_cnt",   32'(stall_cnt_a), 32'(v.e_cnt));
    endtask

    task automatic checkModel(input int c);
        logic [1:0] s0, s1;
        logic ms, st;
        logic [15:0] cnt;
        if (c == 0) begin
            s0 = ex_fwd_sel_a[1:0]; s1 = ex_fwd_sel_a[3:2];
            ms = mem_src_a; st = stall_a; cnt = stall_cnt_a;
        end else begin
            s0 = ex_fwd_sel_b[1:0]; s1 = ex_fwd_sel_b[3:2];
            ms = mem_src_b; st = stall_b; cnt = stall_cnt_b;
        end
        chk($sformatf("model%0d_sel0", c), 32'(s0), 32'(modelSel(c, hist[c][0].rs0)));
        chk($sformatf("model%0d_sel1", c), 32'(s1), 32'(modelSel(c, hist[c][0].rs1)));
        chk($sformatf("model%0d_memsrc", c), 32'(ms), 32'(modelMemSrc(c)));
        chk($sformatf("model%0d_stall", c), 32'(st), 32'(modelStall(c)));
        chk($sformatf("model%0d_cnt", c), 32'(cnt), 32'(mcnt[c]));
    endtask

    task automatic modelAdvance(input vec_t v);
        bit st;
        for (int c = 0; c < 2; c++) begin
            if (v.rst) begin
                for (int a = 0; a < 4; a++) hist[c][a] = '0;
                mcnt[c] = 0;
            end else begin
                st = modelStall(c);
                if (st && mcnt[c] < 65535) mcnt[c]++;
                for (int a = 3; a >= 1; a--) hist[c][a] = hist[c][a-1];
                if (cur_id.valid && !st && !cur_fl) hist[c][0] = cur_id;
                else hist[c][0] = '0;
            end
        end
    endtask

    task automatic runCycle(input vec_t v, input bit use_tbl);
        applyStimulus(v);
        #1;
        if (v.chk) begin
            if (use_tbl) checkOutput(v);
            checkModel(0);
            checkModel(1);
        end
        modelAdvance(v);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        vec_t r;
        int   stall_cycles;
        bit   saw_stall;

        //         rst v rs0 rs1 rd rw mr mw fl | s0 s1 ms st cnt
        r = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0); r.chk = 0; tbl.push_back(r);
        tbl.push_back(idle());
        tbl.push_back(mk(0, 1, 1, 2, 5, 1, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 5, 2, 6, 1, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 9, 5, 8, 1, 0, 0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 2, 0, 0, 0));
        tbl.push_back(idle());
        tbl.push_back(mk(0, 1, 0, 0, 7, 1, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 7, 1, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 7, 0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0,  1, 0, 0, 0, 0));
        tbl.push_back(idle());
        tbl.push_back(idle());
        tbl.push_back(idle());
        tbl.push_back(mk(0, 1, 1, 0, 3, 1, 1, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 4, 10, 1, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 3, 4, 10, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 2, 0, 4, 1, 1, 0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 2, 4, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0, 4, 1, 1, 0, 0,  0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 4, 6, 0, 0, 0, 1, 0,  0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 1, 4, 6, 0, 0, 0, 1, 0,  0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 2));
        tbl.push_back(mk(0, 1, 0, 0, 9, 1, 1, 0, 0,  0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 1, 9, 0, 11, 1, 0, 0, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 1, 11, 0, 12, 1, 0, 0, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 1, 0, 0, 3, 1, 1, 0, 0,  0, 0, 0, 0, 2));
        tbl.push_back(mk(1, 1, 3, 0, 13, 1, 0, 0, 0, 0, 0, 0, 1, 2));
        tbl.push_back(mk(0, 1, 3, 0, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));

        foreach (tbl[n]) runCycle(tbl[n], 1'b1);

        // Deeper pipeline: a load in EX holds its consumer for two cycles.
        runCycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        runCycle(mk(0, 1, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0);
        stall_cycles = 0;
        for (int n = 0; n < 6; n++) begin
            runCycle(mk(0, 1, 3, 0, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
            saw_stall = stall_b;
            if (!saw_stall) break;
            stall_cycles++;
        end
        chk("deep_stall_len", 32'(stall_cycles), 32'd2);
        runCycle(idle(), 1'b0);
        chk("deep_sel_after_load", 32'(ex_fwd_sel_b[1:0]), 32'd3);

        for (int n = 0; n < 400; n++) begin
            r = mk(($urandom_range(0, 63) == 0) ? 1 : 0,
                   ($urandom_range(0, 3) != 0) ? 1 : 0,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 1),
                   ($urandom_range(0, 2) == 0) ? 1 : 0,
                   ($urandom_range(0, 3) == 0) ? 1 : 0,
                   ($urandom_range(0, 7) == 0) ? 1 : 0,
                   0, 0, 0, 0, 0);
            runCycle(r, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
